// File: rtl/assoc_cache_if.sv
// CPU-side and memory-side bus of the set-associative cache.
// slave = cache view, master = core/memory view.
interface assoc_cache_if #(
  parameter int WIDTH = 32
);
  logic             cpu_req_i;
  logic             cpu_we_i;
  logic [WIDTH-1:0] cpu_addr_i;
  logic [WIDTH-1:0] cpu_wdata_i;
  logic [WIDTH-1:0] cpu_rdata_o;
  logic             cpu_stall_o;
  logic             hit_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic [WIDTH-1:0] mem_rdata_i;
  logic             mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    output cpu_rdata_o, cpu_stall_o, hit_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    input  cpu_rdata_o, cpu_stall_o, hit_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/assoc_cache.sv
// Set-associative write-through / no-write-allocate cache with age-based replacement.
// Define ASSOC_CACHE_STATS_EN to add saturating hit/miss counter outputs.
module assoc_cache #(
  parameter int WIDTH    = 32,
  parameter int SET_BITS = 4,
  parameter int WAYS     = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  assoc_cache_if.slave bus
`ifdef ASSOC_CACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int TAG_BITS = WIDTH - SET_BITS - 2;
  localparam int SETS     = 1 << SET_BITS;
  localparam int AGE_BITS = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e state_q, state_d;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [AGE_BITS-1:0] age_q   [SETS][WAYS];
  logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
  logic [WIDTH-1:0]    data_q  [SETS][WAYS];

  logic [SET_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic                unused_addr;
  logic [WAYS-1:0]     hit_vec;
  logic [AGE_BITS-1:0] hit_way, victim_way, upd_way;
  logic [AGE_BITS-1:0] age_new [WAYS];
  logic                idle_hit, stall, fill_we, wr_hit_we, age_upd, flush_clr;

  assign idx         = bus.cpu_addr_i[SET_BITS+1:2];
  assign tag         = bus.cpu_addr_i[WIDTH-1:SET_BITS+2];
  assign unused_addr = ^bus.cpu_addr_i[1:0];

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = AGE_BITS'(w);
  end

  // Lowest invalid way wins; otherwise the way whose age is zero.
  always_comb begin
    victim_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (age_q[idx][w] == '0) victim_way = AGE_BITS'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[idx][w]) victim_way = AGE_BITS'(w);
  end

  assign bus.hit_o       = bus.cpu_req_i && (|hit_vec);
  assign idle_hit        = bus.hit_o && !flush_i;
  assign bus.cpu_stall_o = stall && rst_ni;
  assign bus.mem_addr_o  = bus.cpu_addr_i;
  assign bus.mem_wdata_o = bus.cpu_wdata_i;

  always_comb begin
    state_d         = state_q;
    stall           = 1'b0;
    bus.cpu_rdata_o = '0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    fill_we         = 1'b0;
    wr_hit_we       = 1'b0;
    age_upd         = 1'b0;
    upd_way         = hit_way;
    flush_clr       = 1'b0;
    case (state_q)
      IDLE: begin
        flush_clr = flush_i;
        if (bus.cpu_req_i) begin
          if (bus.cpu_we_i) begin
            stall   = 1'b1;
            state_d = WRITE;
          end else if (idle_hit) begin
            bus.cpu_rdata_o = data_q[idx][hit_way];
            age_upd         = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        bus.mem_req_o = 1'b1;
        stall         = !bus.mem_ack_i;
        if (bus.mem_ack_i) begin
          bus.cpu_rdata_o = bus.mem_rdata_i;
          fill_we         = 1'b1;
          age_upd         = 1'b1;
          upd_way         = victim_way;
          state_d         = IDLE;
        end
      end
      WRITE: begin
        bus.mem_req_o = 1'b1;
        bus.mem_we_o  = 1'b1;
        stall         = !bus.mem_ack_i;
        if (bus.mem_ack_i) begin
          wr_hit_we = bus.hit_o;
          age_upd   = bus.hit_o;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Touched way becomes youngest; ways younger than it shift down by one.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      age_new[w] = age_q[idx][w];
      if (AGE_BITS'(w) == upd_way)
        age_new[w] = AGE_BITS'(WAYS - 1);
      else if (age_q[idx][w] > age_q[idx][upd_way])
        age_new[w] = age_q[idx][w] - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_BITS'(w);
      end
    end else begin
      state_q <= state_d;
      if (flush_clr)
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      if (fill_we) valid_q[idx][victim_way] <= 1'b1;
      if (age_upd)
        for (int w = 0; w < WAYS; w++) age_q[idx][w] <= age_new[w];
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      tag_q[idx][victim_way]  <= tag;
      data_q[idx][victim_way] <= bus.mem_rdata_i;
    end
    if (wr_hit_we) data_q[idx][hit_way] <= bus.cpu_wdata_i;
  end

`ifdef ASSOC_CACHE_STATS_EN
  logic stat_hit, stat_miss;

  assign stat_hit  = (state_q == IDLE && bus.cpu_req_i && !bus.cpu_we_i && idle_hit) || wr_hit_we;
  assign stat_miss = state_q == IDLE && bus.cpu_req_i && !idle_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (stat_hit && hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1'b1;
      if (stat_miss && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Directed self-checking bench for assoc_cache with an expected-result queue.
module tb_assoc_cache;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  assoc_cache_if bus ();

`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  assoc_cache dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus)
`ifdef ASSOC_CACHE_STATS_EN
    ,
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt)
`endif
  );

  typedef struct {
    logic        hit;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   exp_hits   = 0;
  int   exp_misses = 0;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // One complete CPU access; memory answers lat cycles after the request appears.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic do_flush, input logic exp_hit, input logic [31:0] exp_data,
                               input logic [31:0] mem_data, input int lat, input string name);
    exp_t        e;
    int          stalls;
    bit          done;
    logic [31:0] obs_data;
    e.hit  = exp_hit;
    e.data = exp_data;
    exp_q.push_back(e);
    if (exp_hit && !do_flush) exp_hits++;
    else exp_misses++;
    stalls   = 0;
    done     = 0;
    obs_data = '0;
    @(posedge clk); #1;
    bus.cpu_req_i   = 1'b1;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wdata;
    flush           = do_flush;
    @(negedge clk);
    if (!do_flush) checkOutput({name, ".hit"}, 32'(bus.hit_o), 32'(exp_q[0].hit));
    checkOutput({name, ".idle_mreq"}, 32'(bus.mem_req_o), 32'h0);
    if (!bus.cpu_stall_o) begin
      done     = 1;
      obs_data = bus.cpu_rdata_o;
    end else stalls++;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c < lat + 8 && !done; c++) begin
      if (c == lat) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = mem_data;
      end
      @(negedge clk);
      if (c == 0) begin
        checkOutput({name, ".mreq"}, 32'(bus.mem_req_o), 32'h1);
        checkOutput({name, ".mwe"}, 32'(bus.mem_we_o), 32'(we));
        checkOutput({name, ".maddr"}, bus.mem_addr_o, addr);
        if (we) checkOutput({name, ".mwdata"}, bus.mem_wdata_o, wdata);
      end
      if (!bus.cpu_stall_o) begin
        done     = 1;
        obs_data = bus.cpu_rdata_o;
      end else stalls++;
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0;
    end
    bus.cpu_req_i = 1'b0;
    bus.cpu_we_i  = 1'b0;
    e = exp_q.pop_front();
    checkOutput({name, ".done"}, 32'(done), 32'h1);
    checkOutput({name, ".stalls"}, 32'(stalls), (e.hit && !we && !do_flush) ? 32'd0 : 32'(lat + 1));
    if (!we) checkOutput({name, ".rdata"}, obs_data, e.data);
  endtask

  initial begin
    bus.cpu_req_i   = 1'b1;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = 32'h40;
    bus.cpu_wdata_i = '0;
    bus.mem_rdata_i = '0;
    bus.mem_ack_i   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.stall", 32'(bus.cpu_stall_o), 32'h0);
    checkOutput("rst.mreq", 32'(bus.mem_req_o), 32'h0);
    checkOutput("rst.mwe", 32'(bus.mem_we_o), 32'h0);
    checkOutput("rst.rdata", bus.cpu_rdata_o, 32'h0);
    checkOutput("rst.valid0", 32'(dut.valid_q[0]), 32'h0);
    checkOutput("rst.age5", 32'({dut.age_q[5][0], dut.age_q[5][1], dut.age_q[5][2], dut.age_q[5][3]}), 32'h1B);
    bus.cpu_req_i = 1'b0;
    rst_n = 1'b1;

    // Stray ack with no request in IDLE must do nothing.
    @(posedge clk); #1;
    bus.mem_ack_i = 1'b1;
    @(negedge clk);
    checkOutput("idle.stall", 32'(bus.cpu_stall_o), 32'h0);
    checkOutput("idle.mreq", 32'(bus.mem_req_o), 32'h0);
    @(posedge clk); #1;
    bus.mem_ack_i = 1'b0;
    checkOutput("idle.valid0", 32'(dut.valid_q[0]), 32'h0);

    applyStimulus(1'b0, 32'h40, '0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 3, "rd40");
    checkOutput("rd40.valid0", 32'(dut.valid_q[0]), 32'h1);
    checkOutput("rd40.age0", 32'({dut.age_q[0][0], dut.age_q[0][1], dut.age_q[0][2], dut.age_q[0][3]}), 32'hC6);
    applyStimulus(1'b0, 32'h40, '0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 0, "rd40hit");

    applyStimulus(1'b0, 32'h80, '0, 1'b0, 1'b0, 32'hA0000080, 32'hA0000080, 1, "rd80");
    applyStimulus(1'b0, 32'hC0, '0, 1'b0, 1'b0, 32'hA00000C0, 32'hA00000C0, 1, "rdC0");
    applyStimulus(1'b0, 32'h100, '0, 1'b0, 1'b0, 32'hA0000100, 32'hA0000100, 1, "rd100");
    checkOutput("full.valid0", 32'(dut.valid_q[0]), 32'hF);
    checkOutput("full.age0", 32'({dut.age_q[0][0], dut.age_q[0][1], dut.age_q[0][2], dut.age_q[0][3]}), 32'h1B);
    applyStimulus(1'b0, 32'h140, '0, 1'b0, 1'b0, 32'hA0000140, 32'hA0000140, 2, "rd140");
    checkOutput("evict.age0", 32'({dut.age_q[0][0], dut.age_q[0][1], dut.age_q[0][2], dut.age_q[0][3]}), 32'hC6);
    applyStimulus(1'b0, 32'h40, '0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1, "rd40again");
    applyStimulus(1'b0, 32'hC0, '0, 1'b0, 1'b1, 32'hA00000C0, 32'h0, 0, "rdC0hit");

    applyStimulus(1'b1, 32'h100, 32'h12345678, 1'b0, 1'b1, 32'h0, 32'h0, 2, "wr100");
    applyStimulus(1'b0, 32'h100, '0, 1'b0, 1'b1, 32'h12345678, 32'h0, 0, "rd100hit");
    applyStimulus(1'b1, 32'h208, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'h0, 1, "wr208");
    checkOutput("wrmiss.valid2", 32'(dut.valid_q[2]), 32'h0);
    checkOutput("wrmiss.valid0", 32'(dut.valid_q[0]), 32'hF);
`ifdef ASSOC_CACHE_STATS_EN
    checkOutput("stats1.hit", hit_cnt, 32'(exp_hits));
    checkOutput("stats1.miss", miss_cnt, 32'(exp_misses));
`endif

    // Reset in the middle of a fill, with an ack arriving during and after it.
    @(posedge clk); #1;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h0C;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midrst.mreq_pre", 32'(bus.mem_req_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst.mreq", 32'(bus.mem_req_o), 32'h0);
    checkOutput("midrst.stall", 32'(bus.cpu_stall_o), 32'h0);
    checkOutput("midrst.rdata", bus.cpu_rdata_o, 32'h0);
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'h55555555;
    bus.cpu_req_i   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    exp_hits   = 0;
    exp_misses = 0;
    @(posedge clk); #1;
    bus.mem_ack_i = 1'b0;
    checkOutput("midrst.valid3", 32'(dut.valid_q[3]), 32'h0);
    checkOutput("midrst.valid0", 32'(dut.valid_q[0]), 32'h0);
    applyStimulus(1'b0, 32'h0C, '0, 1'b0, 1'b0, 32'hC0C0000C, 32'hC0C0000C, 1, "rd0C");

    applyStimulus(1'b0, 32'h10, '0, 1'b0, 1'b0, 32'hC0C00010, 32'hC0C00010, 1, "rd10");
    applyStimulus(1'b0, 32'h14, '0, 1'b0, 1'b0, 32'hC0C00014, 32'hC0C00014, 1, "rd14");
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush.valid3", 32'(dut.valid_q[3]), 32'h0);
    checkOutput("flush.valid4", 32'(dut.valid_q[4]), 32'h0);
    checkOutput("flush.age3", 32'({dut.age_q[3][0], dut.age_q[3][1], dut.age_q[3][2], dut.age_q[3][3]}), 32'hC6);
    applyStimulus(1'b0, 32'h0C, '0, 1'b0, 1'b0, 32'h1111000C, 32'h1111000C, 1, "fl.rd0C");
    applyStimulus(1'b0, 32'h0C, '0, 1'b1, 1'b0, 32'h2222000C, 32'h2222000C, 1, "fl.req0C");
    applyStimulus(1'b0, 32'h14, '0, 1'b0, 1'b0, 32'h33330014, 32'h33330014, 1, "fl.rd14");
`ifdef ASSOC_CACHE_STATS_EN
    checkOutput("stats2.hit", hit_cnt, 32'(exp_hits));
    checkOutput("stats2.miss", miss_cnt, 32'(exp_misses));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameters: WIDTH 32 data/address bits; SET_BITS 4, giving 2**SET_BITS sets; WAYS 4, a power of two from 2 to 8; TAG_BITS = WIDTH-SET_BITS-2.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk_i  in  1  clock; all state changes on rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 cpu_req_i  in  1  access request.
REQ-006 cpu_we_i  in  1  1 = write, 0 = read.
REQ-007 cpu_addr_i  in  WIDTH  word address; index = [SET_BITS+1:2], tag = [WIDTH-1:SET_BITS+2], bits [1:0] ignored.
REQ-008 cpu_wdata_i  in  WIDTH  write data.
REQ-009 cpu_rdata_o  out  WIDTH  read data.
REQ-010 cpu_stall_o  out  1  request not complete; core holds all cpu_* inputs stable while this is high.
REQ-011 hit_o  out  1  combinational lookup hit (cpu_req_i and tag match on a valid way).
REQ-012 flush_i  in  1  invalidate all lines.
REQ-013 mem_req_o  out  1  memory request.
REQ-014 mem_we_o  out  1  memory write.
REQ-015 mem_addr_o  out  WIDTH  memory address, equal to cpu_addr_i.
REQ-016 mem_wdata_o  out  WIDTH  memory write data.
REQ-017 mem_rdata_i  in  WIDTH  memory read data, valid with mem_ack_i.
REQ-018 mem_ack_i  in  1  one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have three states: IDLE, FILL and WRITE.
REQ-020 IDLE, read hit: cpu_rdata_o = hit way data in the same cycle; cpu_stall_o = 0; state stays IDLE.
REQ-021 IDLE, read miss: cpu_stall_o = 1 combinationally; next state FILL.
REQ-022 FILL: mem_req_o = 1, mem_we_o = 0; cpu_stall_o = 1 until mem_ack_i.
REQ-023 FILL, ack cycle: cpu_rdata_o = mem_rdata_i; cpu_stall_o = 0; victim way gets data, tag and valid at the clock edge; next state IDLE.
REQ-024 IDLE, any write: cpu_stall_o = 1; next state WRITE.
REQ-025 WRITE: mem_req_o = 1, mem_we_o = 1, mem_wdata_o = cpu_wdata_i; on mem_ack_i, cpu_stall_o = 0 and next state IDLE.
REQ-026 Write policy: write-through, no-write-allocate; a write hit updates the hit way's data at the ack edge; a write miss leaves cache contents unchanged.
REQ-027 Victim selection: lowest-index invalid way in the set; if none is invalid, the way with age 0.
REQ-028 Ages: one per way, $clog2(WAYS) bits, per set; all ages in a set remain a permutation of 0..WAYS-1.
REQ-029 Age update on a completed read hit, fill, or write hit to way w of old age a: w becomes WAYS-1; every way in that set with age > a decrements; all other ways are unchanged.
REQ-030 A write miss and an idle cycle SHALL NOT change any age.
REQ-031 mem_req_o SHALL be 0 in IDLE; mem_ack_i is ignored in IDLE.
REQ-032 flush_i sampled in IDLE clears every valid bit at the next edge and leaves ages unchanged.
REQ-033 flush_i asserted in IDLE together with cpu_req_i: the flush takes effect and the request is treated as a miss.
REQ-034 flush_i asserted in FILL or WRITE is ignored.
REQ-035 cpu_req_i = 0 in IDLE: no state change; cpu_stall_o = 0.

Reset
REQ-036 While rst_ni = 0: state IDLE; all valid bits 0; age[s][w] = w; mem_req_o = 0; mem_we_o = 0; cpu_stall_o = 0; cpu_rdata_o = 0.
REQ-037 Reset asserted during FILL or WRITE aborts the access immediately; no line is written.
REQ-038 A mem_ack_i that arrives during or after reset is ignored.
REQ-039 Data and tag arrays are not reset.

Configuration
REQ-040 With ASSOC_CACHE_STATS_EN defined, the block SHALL add 32-bit outputs hit_cnt_o and miss_cnt_o, reset to 0.
REQ-041 hit_cnt_o increments once per completed hit; miss_cnt_o increments once per entry to FILL or to WRITE on a miss; both saturate at 0xFFFFFFFF.
REQ-042 Without ASSOC_CACHE_STATS_EN, these ports and counters SHALL be absent.

Verification
REQ-043 Reset, then read 0x0000_0040 (set 0), memory returns 0xDEADBEEF after 3 cycles -> stall for 4 cycles, data returned, way 0 valid, ages {3,0,1,2}; repeated read -> hit, no stall, 0xDEADBEEF.
REQ-044 Fill set 0 with 5 distinct tags, WAYS = 4 -> fifth fill evicts the first-filled way; re-reading the first tag misses.
REQ-045 Write 0x12345678 to a resident address -> one WRITE transaction with mem_we_o = 1, then a read hits and returns 0x12345678; a write to an absent address -> no valid bit changes.
REQ-046 rst_ni pulsed low mid-FILL, then mem_ack_i -> mem_req_o drops asynchronously; after reset, a read of the same address misses.
REQ-047 flush_i in IDLE after 3 fills -> all subsequent reads miss; with ASSOC_CACHE_STATS_EN defined, hit_cnt_o and miss_cnt_o match the counted events.
